// File: rtl/uart_rx_flex.sv
// UART receiver with runtime-selectable baud rate, mid-bit sampling and a
// valid/ready holding register with frame-error and overrun pulses.
module uart_rx_flex #(
    parameter int unsigned CLK_FRE = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_pin,
    input  logic [2:0] baudrate,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    input  logic       rx_data_ready,
    output logic       rx_frame_err,
    output logic       rx_overrun
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CLK_HZ = CLK_FRE * 1000000;

    localparam logic [CNT_W-1:0] LEN_4800   = CNT_W'(CLK_HZ / 4800);
    localparam logic [CNT_W-1:0] LEN_9600   = CNT_W'(CLK_HZ / 9600);
    localparam logic [CNT_W-1:0] LEN_19200  = CNT_W'(CLK_HZ / 19200);
    localparam logic [CNT_W-1:0] LEN_38400  = CNT_W'(CLK_HZ / 38400);
    localparam logic [CNT_W-1:0] LEN_57600  = CNT_W'(CLK_HZ / 57600);
    localparam logic [CNT_W-1:0] LEN_115200 = CNT_W'(CLK_HZ / 115200);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              rx_d1;
    logic              rx_s;
    logic              rx_q;
    logic [CNT_W-1:0]  cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  cycle_len;
    logic [CNT_W-1:0]  half_len;
    logic [CNT_W-1:0]  baud_len;
    logic [DATA_W-1:0] shreg;
    logic              data_hit;
    logic              stop_hit;

    // Bit period for the currently selected rate; only used at frame start.
    always_comb begin
        baud_len = LEN_115200;
        case (baudrate)
            3'b000:  baud_len = LEN_4800;
            3'b001:  baud_len = LEN_9600;
            3'b010:  baud_len = LEN_19200;
            3'b011:  baud_len = LEN_38400;
            3'b100:  baud_len = LEN_57600;
            default: baud_len = LEN_115200;
        endcase
    end

    assign half_len = cycle_len >> 1;

    // Two-flop synchronizer plus one flop for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_d1 <= 1'b1;
            rx_s  <= 1'b1;
            rx_q  <= 1'b1;
        end else begin
            rx_d1 <= rx_pin;
            rx_s  <= rx_d1;
            rx_q  <= rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        data_hit  = 1'b0;
        stop_hit  = 1'b0;
        case (state)
            S_IDLE: begin
                if (rx_q && !rx_s) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                if (cnt == half_len - CNT_W'(1)) begin
                    state_nxt = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt == cycle_len - CNT_W'(1)) begin
                    data_hit = 1'b1;
                    if (bit_cnt == BIT_W'(7)) begin
                        state_nxt = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (cnt == cycle_len - CNT_W'(1)) begin
                    stop_hit  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bit timing counters, latched bit period and data shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            bit_cnt   <= '0;
            cycle_len <= LEN_115200;
            shreg     <= '0;
        end else begin
            if (state == S_IDLE && state_nxt == S_START) begin
                cycle_len <= baud_len;
            end
            if (data_hit) begin
                shreg[bit_cnt] <= rx_s;
            end
            if (state != state_nxt) begin
                cnt     <= '0;
                bit_cnt <= '0;
            end else if (data_hit) begin
                cnt     <= '0;
                bit_cnt <= bit_cnt + BIT_W'(1);
            end else if (state != S_IDLE) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Holding register: accept and reload in the same cycle is not an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data       <= '0;
            rx_data_valid <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            rx_frame_err <= stop_hit && !rx_s;
            rx_overrun   <= 1'b0;
            if (stop_hit && rx_s) begin
                if (!rx_data_valid || rx_data_ready) begin
                    rx_data       <= shreg;
                    rx_data_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_data_valid && rx_data_ready) begin
                rx_data_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_flex.sv
// Scoreboard bench for uart_rx_flex: expected bytes/pulses are queued as frames
// are driven and matched against handshakes and pulses seen on the outputs.
module tb_uart_rx_flex;

    // 20 MHz keeps the 4800-baud frame inside the cycle budget.
    localparam int unsigned CLK_FRE  = 20;
    localparam int          BIT_FAST = 173;   // 20e6/115200 truncated
    localparam int          BIT_SLOW = 4166;  // 20e6/4800 truncated

    localparam logic [1:0] EV_DATA = 2'd0;
    localparam logic [1:0] EV_ERR  = 2'd1;
    localparam logic [1:0] EV_OVR  = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] data;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       rx_pin;
    logic [2:0] baudrate;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       rx_data_ready;
    logic       rx_frame_err;
    logic       rx_overrun;

    ev_t sb[$];
    int  n_checks;
    int  n_errors;

    uart_rx_flex #(.CLK_FRE(CLK_FRE)) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_pin        (rx_pin),
        .baudrate      (baudrate),
        .rx_data       (rx_data),
        .rx_data_valid (rx_data_valid),
        .rx_data_ready (rx_data_ready),
        .rx_frame_err  (rx_frame_err),
        .rx_overrun    (rx_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic sb_match(input logic [1:0] kind, input logic [7:0] data);
        ev_t ev;
        if (sb.size() == 0) begin
            check("sb_unexpected_event", 32'(kind), 32'hff);
        end else begin
            ev = sb.pop_front();
            check("ev_kind", 32'(kind), 32'(ev.kind));
            if (ev.kind == EV_DATA) begin
                check("ev_data", 32'(data), 32'(ev.data));
            end
        end
    endtask

    // Output monitor: each accepted byte and each pulse is one scoreboard event.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_data_valid && rx_data_ready) sb_match(EV_DATA, rx_data);
            if (rx_frame_err)                  sb_match(EV_ERR, 8'h00);
            if (rx_overrun)                    sb_match(EV_OVR, 8'h00);
        end
    end

    task automatic push_ev(input logic [1:0] kind, input logic [7:0] data);
        ev_t ev;
        ev.kind = kind;
        ev.data = data;
        sb.push_back(ev);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic drive_bit(input logic v, input int len);
        rx_pin = v;
        wait_cycles(len);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_v, input int len,
                             input bit switch_fast);
        drive_bit(1'b0, len);
        for (int i = 0; i < 8; i++) begin
            drive_bit(d[i], len);
            if (switch_fast && i == 2) baudrate = 3'b101;
        end
        drive_bit(stop_v, len);
        rx_pin = 1'b1;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        rx_pin        = 1'b1;
        baudrate      = 3'b101;
        rx_data_ready = 1'b1;
        wait_cycles(5);
        rst = 1'b0;
        wait_cycles(2);

        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_valid", 32'(rx_data_valid), 32'h0);
        check("rst_frame_err", 32'(rx_frame_err), 32'h0);
        check("rst_overrun", 32'(rx_overrun), 32'h0);

        // Back-to-back frames with consumer always ready.
        push_ev(EV_DATA, 8'h55);
        send_byte(8'h55, 1'b1, BIT_FAST, 1'b0);
        push_ev(EV_DATA, 8'hA3);
        send_byte(8'hA3, 1'b1, BIT_FAST, 1'b0);
        wait_cycles(20);

        // Short low pulse shorter than half a bit is rejected as a glitch.
        drive_bit(1'b0, 40);
        drive_bit(1'b1, 300);
        check("glitch_valid", 32'(rx_data_valid), 32'h0);
        push_ev(EV_DATA, 8'h3C);
        send_byte(8'h3C, 1'b1, BIT_FAST, 1'b0);
        wait_cycles(20);

        // Stop bit low: error pulse, holding register untouched.
        push_ev(EV_ERR, 8'h00);
        send_byte(8'hA3, 1'b0, BIT_FAST, 1'b0);
        wait_cycles(20);
        check("ferr_valid", 32'(rx_data_valid), 32'h0);
        check("ferr_rx_data", 32'(rx_data), 32'h3C);

        // Consumer stalled: second byte overruns and is dropped.
        rx_data_ready = 1'b0;
        send_byte(8'h12, 1'b1, BIT_FAST, 1'b0);
        push_ev(EV_OVR, 8'h00);
        send_byte(8'h34, 1'b1, BIT_FAST, 1'b0);
        wait_cycles(20);
        check("ovr_rx_data", 32'(rx_data), 32'h12);
        check("ovr_valid", 32'(rx_data_valid), 32'h1);
        push_ev(EV_DATA, 8'h12);
        rx_data_ready = 1'b1;
        wait_cycles(1);
        rx_data_ready = 1'b0;
        @(negedge clk);
        check("accept_clears_valid", 32'(rx_data_valid), 32'h0);
        wait_cycles(5);
        rx_data_ready = 1'b1;

        // Slow frame with baud change mid-frame, then a fast frame.
        baudrate = 3'b000;
        wait_cycles(2);
        push_ev(EV_DATA, 8'hC8);
        send_byte(8'hC8, 1'b1, BIT_SLOW, 1'b1);
        check("baud_switched", 32'(baudrate), 32'h5);
        push_ev(EV_DATA, 8'h5A);
        send_byte(8'h5A, 1'b1, BIT_FAST, 1'b0);
        wait_cycles(20);

        // Reset in the middle of a 0xFF frame aborts it silently.
        drive_bit(1'b0, BIT_FAST);
        drive_bit(1'b1, 3 * BIT_FAST);
        rst = 1'b1;
        wait_cycles(4);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_rx_data", 32'(rx_data), 32'h00);
        check("midrst_valid", 32'(rx_data_valid), 32'h0);
        wait_cycles(2000);
        check("midrst_quiet_valid", 32'(rx_data_valid), 32'h0);
        push_ev(EV_DATA, 8'h81);
        send_byte(8'h81, 1'b1, BIT_FAST, 1'b0);

        for (int i = 0; i < 1000 && sb.size() != 0; i++) wait_cycles(1);
        check("sb_drained", 32'(sb.size()), 32'h0);
        wait_cycles(10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
